// File: rtl/goertzel_detector.sv
// goertzel_detector
// Sequences a Goertzel power stage, keeps a sliding average over the last
// 2^AVG_POW2 block powers and raises a hysteretic tone-detect flag.
//
// Parameters
//   PW        width of the block power result
//   AVG_POW2  log2 of the averaging window depth in blocks (1..4)
//
// Ports
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   enable_i      keep launching blocks while high
//   clear_i       synchronous clear of averaging history and detect state
//   thresh_on_i   detect asserts when average >= this
//   thresh_off_i  detect deasserts when average < this
//   done_i        power-stage done pulse
//   power_i       power-stage result, valid while done_i is high
//   start_o       one-cycle start strobe to the power stage
//   avg_o         averaged power over a full window
//   avg_valid_o   one-cycle pulse when avg_o is refreshed
//   detect_o      hysteretic detect flag
//   busy_o        high whenever the sequencer is not idle
module goertzel_detector #(
  parameter int PW       = 32,
  parameter int AVG_POW2 = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          enable_i,
  input  logic          clear_i,
  input  logic [PW-1:0] thresh_on_i,
  input  logic [PW-1:0] thresh_off_i,
  input  logic          done_i,
  input  logic [PW-1:0] power_i,
  output logic          start_o,
  output logic [PW-1:0] avg_o,
  output logic          avg_valid_o,
  output logic          detect_o,
  output logic          busy_o
);

  localparam int DEPTH = 1 << AVG_POW2;
  localparam int SW    = PW + AVG_POW2;
  localparam int FW    = AVG_POW2 + 1;

  localparam logic [AVG_POW2-1:0] PTR_ONE   = AVG_POW2'(1'b1);
  localparam logic [FW-1:0]       FILL_ONE  = FW'(1'b1);
  localparam logic [FW-1:0]       FILL_FULL = FW'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_WAIT    = 3'd2,
    S_UPDATE  = 3'd3,
    S_COMPARE = 3'd4
  } state_t;

  state_t                state_r;
  logic [PW-1:0]         capture_r;
  logic                  discard_r;   // block result arrived together with clear_i
  logic [PW-1:0]         hist_r [DEPTH];
  logic [AVG_POW2-1:0]   wr_ptr_r;
  logic [FW-1:0]         fill_r;
  logic [SW-1:0]         sum_r;       // AVG_POW2 extra bits: sum of DEPTH values never overflows
  logic [PW-1:0]         avg_r;
  logic                  avg_valid_r;
  logic                  detect_r;

  logic                  full_s;
  logic [PW-1:0]         old_s;
  logic [SW-1:0]         sum_next_s;
  logic [PW-1:0]         avg_s;

  // Window arithmetic: evicted entry, running-sum update and truncated average.
  always_comb begin
    full_s = (fill_r == FILL_FULL);
    if (full_s) begin
      old_s = hist_r[wr_ptr_r];
    end else begin
      // Entries beyond the fill level are stale and must not be subtracted.
      old_s = {PW{1'b0}};
    end
    sum_next_s = sum_r - {{AVG_POW2{1'b0}}, old_s} + {{AVG_POW2{1'b0}}, capture_r};
    avg_s      = sum_r[SW-1:AVG_POW2];
  end

  // Sequencer plus averaging/detect datapath; clear_i overrides any update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      capture_r   <= {PW{1'b0}};
      discard_r   <= 1'b0;
      wr_ptr_r    <= {AVG_POW2{1'b0}};
      fill_r      <= {FW{1'b0}};
      sum_r       <= {SW{1'b0}};
      avg_r       <= {PW{1'b0}};
      avg_valid_r <= 1'b0;
      detect_r    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        hist_r[i] <= {PW{1'b0}};
      end
    end else begin
      avg_valid_r <= 1'b0;

      case (state_r)
        S_IDLE: begin
          if (enable_i) begin
            state_r <= S_START;
          end else begin
            state_r <= S_IDLE;
          end
        end

        S_START: begin
          state_r <= S_WAIT;
        end

        S_WAIT: begin
          // The power stage cannot be aborted, so enable_i is not looked at here.
          if (done_i) begin
            capture_r <= power_i;
            discard_r <= clear_i;
            state_r   <= S_UPDATE;
          end else begin
            state_r   <= S_WAIT;
          end
        end

        S_UPDATE: begin
          if (!clear_i && !discard_r) begin
            sum_r            <= sum_next_s;
            hist_r[wr_ptr_r] <= capture_r;
            wr_ptr_r         <= wr_ptr_r + PTR_ONE;
            if (!full_s) begin
              fill_r <= fill_r + FILL_ONE;
            end
          end
          state_r <= S_COMPARE;
        end

        S_COMPARE: begin
          if (!clear_i && !discard_r && full_s) begin
            avg_r       <= avg_s;
            avg_valid_r <= 1'b1;
            if (!detect_r && (avg_s >= thresh_on_i)) begin
              detect_r <= 1'b1;
            end else if (detect_r && (avg_s < thresh_off_i)) begin
              detect_r <= 1'b0;
            end
          end
          discard_r <= 1'b0;
          if (enable_i) begin
            state_r <= S_START;
          end else begin
            state_r <= S_IDLE;
          end
        end

        default: begin
          state_r <= S_IDLE;
        end
      endcase

      // Clear wins over any UPDATE/COMPARE write above; buffer contents stay stale.
      if (clear_i) begin
        sum_r       <= {SW{1'b0}};
        fill_r      <= {FW{1'b0}};
        wr_ptr_r    <= {AVG_POW2{1'b0}};
        avg_r       <= {PW{1'b0}};
        avg_valid_r <= 1'b0;
        detect_r    <= 1'b0;
      end
    end
  end

  // Strobe and busy are decoded straight from the state register.
  assign start_o     = (state_r == S_START);
  assign busy_o      = (state_r != S_IDLE);
  assign avg_o       = avg_r;
  assign avg_valid_o = avg_valid_r;
  assign detect_o    = detect_r;

endmodule

// File: tb/tb_goertzel_detector.sv
// Directed testbench for goertzel_detector (PW=32, AVG_POW2=2).
// The bench plays the power stage: it answers each start_o with a done_i
// pulse after a per-vector latency and checks the averaged result.
module tb_goertzel_detector;

  localparam int PW = 32;
  localparam int NV = 18;

  logic          clk;
  logic          rst_n;
  logic          enable_i;
  logic          clear_i;
  logic [PW-1:0] thresh_on_i;
  logic [PW-1:0] thresh_off_i;
  logic          done_i;
  logic [PW-1:0] power_i;
  logic          start_o;
  logic [PW-1:0] avg_o;
  logic          avg_valid_o;
  logic          detect_o;
  logic          busy_o;

  int checks;
  int errors;

  typedef struct {
    logic [PW-1:0] power;
    int            lat;
    logic [PW-1:0] on_th;
    logic [PW-1:0] off_th;
    logic          exp_valid;
    logic [PW-1:0] exp_avg;
    logic          exp_det;
  } vec_t;

  vec_t vecs [NV];

  goertzel_detector #(.PW(PW), .AVG_POW2(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable_i     (enable_i),
    .clear_i      (clear_i),
    .thresh_on_i  (thresh_on_i),
    .thresh_off_i (thresh_off_i),
    .done_i       (done_i),
    .power_i      (power_i),
    .start_o      (start_o),
    .avg_o        (avg_o),
    .avg_valid_o  (avg_valid_o),
    .detect_o     (detect_o),
    .busy_o       (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Wait (bounded) until start_o is seen high at a falling edge.
  task automatic wait_start(input string name);
    int n;
    n = 0;
    while (start_o !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({name, " start_timeout"}, start_o, 1);
  endtask

  // Play one power-stage block: done_i after lat cycles, then step to the
  // falling edge after the COMPARE edge, where the new outputs are visible.
  task automatic run_block(input string name, input logic [PW-1:0] p, input int lat, input logic clr);
    repeat (lat) @(negedge clk);
    done_i  = 1'b1;
    power_i = p;
    clear_i = clr;
    @(negedge clk);
    done_i  = 1'b0;
    power_i = '0;
    clear_i = 1'b0;
    check({name, " start_in_update"}, start_o, 0);
    check({name, " busy_in_update"}, busy_o, 1);
    @(negedge clk);
    check({name, " start_in_compare"}, start_o, 0);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int seen;
    int vcount;

    checks = 0;
    errors = 0;

    //            power lat  on   off  valid avg  det
    vecs[0]  = '{32'd100,  1, 32'd400, 32'd300, 1'b0, 32'd0,   1'b0};
    vecs[1]  = '{32'd200,  2, 32'd400, 32'd300, 1'b0, 32'd0,   1'b0};
    vecs[2]  = '{32'd300,  3, 32'd400, 32'd300, 1'b0, 32'd0,   1'b0};
    vecs[3]  = '{32'd400,  1, 32'd400, 32'd300, 1'b1, 32'd250, 1'b0};
    vecs[4]  = '{32'd800,  2, 32'd400, 32'd300, 1'b1, 32'd425, 1'b1};
    vecs[5]  = '{32'd1,    1, 32'd400, 32'd300, 1'b1, 32'd375, 1'b1};
    vecs[6]  = '{32'd1,    1, 32'd400, 32'd300, 1'b1, 32'd300, 1'b1};
    vecs[7]  = '{32'd1,    4, 32'd400, 32'd300, 1'b1, 32'd200, 1'b0};
    vecs[8]  = '{32'd1,    1, 32'd400, 32'd300, 1'b1, 32'd1,   1'b0};
    vecs[9]  = '{32'd500,  1, 32'd400, 32'd300, 1'b1, 32'd125, 1'b0};
    vecs[10] = '{32'd500,  2, 32'd400, 32'd300, 1'b1, 32'd250, 1'b0};
    vecs[11] = '{32'd500,  1, 32'd400, 32'd300, 1'b1, 32'd375, 1'b0};
    vecs[12] = '{32'd500,  3, 32'd400, 32'd300, 1'b1, 32'd500, 1'b1};
    vecs[13] = '{32'd200,  1, 32'd400, 32'd300, 1'b1, 32'd425, 1'b1};
    vecs[14] = '{32'd200,  1, 32'd400, 32'd300, 1'b1, 32'd350, 1'b1};
    vecs[15] = '{32'd296,  2, 32'd400, 32'd300, 1'b1, 32'd299, 1'b0};
    vecs[16] = '{32'd704,  1, 32'd400, 32'd300, 1'b1, 32'd350, 1'b0};
    vecs[17] = '{32'd400,  1, 32'd400, 32'd300, 1'b1, 32'd400, 1'b1};

    rst_n        = 1'b0;
    enable_i     = 1'b1;
    clear_i      = 1'b0;
    done_i       = 1'b0;
    power_i      = '0;
    thresh_on_i  = 32'd400;
    thresh_off_i = 32'd300;

    // Reset held for 3 cycles with enable high: everything stays quiet.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("reset_outputs_c%0d", c),
            {start_o, busy_o, avg_valid_o, detect_o, avg_o}, '0);
    end
    rst_n = 1'b1;

    // First enabled edge after release launches exactly one start pulse.
    seen = 0;
    @(negedge clk);
    check("reset_release_start", start_o, 1);
    if (start_o) seen++;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (start_o) seen++;
    end
    check("reset_release_start_count", seen, 1);

    // Window fill, sliding/wrap, truncation and hysteresis vectors.
    for (int i = 0; i < NV; i++) begin
      thresh_on_i  = vecs[i].on_th;
      thresh_off_i = vecs[i].off_th;
      run_block($sformatf("vec%0d", i), vecs[i].power, vecs[i].lat, 1'b0);
      check($sformatf("vec%0d avg_valid", i), avg_valid_o, vecs[i].exp_valid);
      check($sformatf("vec%0d avg", i), avg_o, vecs[i].exp_avg);
      check($sformatf("vec%0d detect", i), detect_o, vecs[i].exp_det);
      check($sformatf("vec%0d next_start", i), start_o, 1);
    end

    // clear_i coincident with done_i while detect is set: result discarded.
    run_block("clear", 32'd9999, 1, 1'b1);
    check("clear avg", avg_o, 0);
    check("clear detect", detect_o, 0);
    check("clear avg_valid", avg_valid_o, 0);
    check("clear next_start", start_o, 1);

    // Refill after clear: only the 4th block produces a valid average.
    vcount = 0;
    for (int b = 0; b < 4; b++) begin
      run_block($sformatf("refill%0d", b), 32'd500, 1, 1'b0);
      if (avg_valid_o) vcount++;
      check($sformatf("refill%0d avg_valid", b), avg_valid_o, (b == 3) ? 1 : 0);
    end
    check("refill valid_count", vcount, 1);
    check("refill avg", avg_o, 500);
    check("refill detect", detect_o, 1);

    // enable_i dropped while waiting: the pending block still completes.
    @(negedge clk);
    enable_i = 1'b0;
    run_block("disable", 32'd700, 2, 1'b0);
    check("disable avg_valid", avg_valid_o, 1);
    check("disable avg", avg_o, 550);
    check("disable detect", detect_o, 1);
    check("disable no_start", start_o, 0);
    check("disable busy_low", busy_o, 0);
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (start_o || busy_o || avg_valid_o) seen++;
    end
    check("disable idle_quiet", seen, 0);

    // done_i while idle is ignored.
    done_i  = 1'b1;
    power_i = 32'd5;
    @(negedge clk);
    done_i  = 1'b0;
    power_i = '0;
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (start_o || busy_o || avg_valid_o) seen++;
    end
    check("idle_done quiet", seen, 0);
    check("idle_done avg", avg_o, 550);
    check("idle_done detect", detect_o, 1);

    // Reset in the middle of a block returns everything to reset values.
    enable_i = 1'b1;
    @(negedge clk);
    wait_start("midreset");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset outputs", {start_o, busy_o, avg_valid_o, detect_o, avg_o}, '0);
    @(negedge clk);
    check("midreset held", {start_o, busy_o}, '0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/goertzel_detector.md
# goertzel_detector

Downstream consumer of the Goertzel power stage. It drives that stage's start strobe and captures each block power result on its done pulse. It keeps a sliding average over the last 2^AVG_POW2 blocks and raises a hysteretic tone-detect flag when the average crosses programmable on/off thresholds. It also exports the averaged power for status readout.

## Interface
- PW, 32, width of block power input (2·DW of the power stage)
- AVG_POW2, 2, log2 of averaging window depth in blocks (1..4)

- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- enable_i  in  1  run continuously while high
- clear_i  in  1  synchronous clear of averaging history and detect state
- thresh_on_i  in  PW  detect asserts when avg ≥ this
- thresh_off_i  in  PW  detect deasserts when avg < this
- done_i  in  1  power-stage done pulse
- power_i  in  PW  power-stage result, valid while done_i high
- start_o  out  1  one-cycle start strobe to power stage
- avg_o  out  PW  averaged power
- avg_valid_o  out  1  one-cycle pulse, avg_o updated with full window
- detect_o  out  1  hysteretic detect flag
- busy_o  out  1  high whenever state ≠ IDLE

## Operation
- Storage:
  - history buffer of 2^AVG_POW2 × PW registers
  - wr_ptr of AVG_POW2 bits, wraps modulo depth
  - fill counter saturating at 2^AVG_POW2
  - sum of PW+AVG_POW2 bits, so it cannot overflow
- FSM: IDLE, START, WAIT, UPDATE, COMPARE.
  - IDLE: go to START if enable_i is high.
  - START: start_o=1 this cycle only; go to WAIT.
  - WAIT: sample done_i each cycle; on done_i=1, latch power_i into a capture register and go to UPDATE. The FSM stays in WAIT while done_i=0, regardless of enable_i, because the power stage cannot be aborted.
  - UPDATE:
    - Compute sum ← sum − old + capture, where old = buf[wr_ptr] if fill is full, else 0.
    - Write buf[wr_ptr] ← capture, advance wr_ptr, and increment fill if not full.
    - Go to COMPARE.
  - COMPARE: avg = sum >> AVG_POW2 (truncating). Behaviour depends on fill:
    - Fill full: avg_o ← avg and avg_valid_o pulses.
      - If detect_o=0 and avg ≥ thresh_on_i, set detect_o=1.
      - If detect_o=1 and avg < thresh_off_i, clear detect_o=0.
    - Fill not full: avg_o, avg_valid_o and detect_o are unchanged.
    - Next state: START if enable_i is high, else IDLE.
- All comparisons are unsigned.
- thresh_off_i > thresh_on_i is legal. The detect flag then simply toggles per the two rules above.
- done_i outside WAIT is ignored.
- clear_i, in any state, has priority over UPDATE/COMPARE writes:
  - Zeroes sum, fill, wr_ptr, avg_o and detect_o.
  - Suppresses avg_valid_o.
  - Buffer contents are left stale; the fill gating makes them irrelevant.
  - The FSM state still advances normally.
  - A done_i coinciding with clear_i is discarded, but the FSM still leaves WAIT.
- Reset mid-block: everything returns to reset values. The power stage is reset by the same system reset.

## Timing
- Reset values: start_o=0, avg_o=0, avg_valid_o=0, detect_o=0, busy_o=0, state IDLE, sum/fill/wr_ptr=0.
- enable_i sampled high in IDLE at edge t → start_o high during cycle t..t+1.
- done_i sampled at edge d: UPDATE during d..d+1, COMPARE during d+1..d+2.
  - avg_o, detect_o and avg_valid_o are visible after edge d+2.
  - start_o for the next block is high during d+2..d+3 if enable_i was high in COMPARE.
- Per-block overhead is 4 cycles beyond the power stage's own latency.
- All outputs are registered or decoded directly from the state register. There are no combinational input→output paths.

## Test plan
- Reset: hold rst_n low for 3 cycles with enable_i=1 → all outputs 0, no start_o. Release → start_o pulses exactly once, one cycle after the first enabled edge.
- Window fill (AVG_POW2=2): with enable_i=1, return powers 100, 200, 300, 400 → avg_valid_o only after the 4th block, avg_o=250. start_o pulses once per block, 2 cycles after each done_i.
- Sliding/wrap: 5th power 800 → avg_o=425. Powers 1, 1, 1, 1 follow → avg_o=1 (truncation, oldest entries evicted).
- Hysteresis: thresh_on=400, thresh_off=300, averages 425 → 350 → 299 → 350 → detect_o 1, 1, 0, 0. An average of exactly 400 sets detect.
- enable_i dropped while in WAIT → the pending done_i is still processed, no further start_o, busy_o falls after COMPARE. A done_i pulse while in IDLE changes nothing.
- clear_i coincident with done_i, with detect_o=1 → detect_o=0, avg_o=0, the result is discarded. The next 4 blocks of 500 give avg_valid_o once, avg_o=500.
